// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory port arbiter:
//   - arb_state_e      : arbiter FSM state encoding
//   - STARVE_LIMIT_DEF : default number of consecutive data grants allowed
//                        while a fetch request is waiting
//   - cnt_width()      : width of a saturating counter that must reach 'limit'
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT_I = 2'b01,
        ST_WAIT_D = 2'b10
    } arb_state_e;

    localparam int STARVE_LIMIT_DEF = 4;

    // Smallest counter width able to hold 'limit'; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        if (limit < 1) begin
            return 1;
        end else begin
            return $clog2(limit + 1);
        end
    endfunction

endpackage : mem_arb_pkg

// File: rtl/arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// arb_starve_cnt
// Saturating starvation counter for the fetch requester. Counts data grants
// that were given while a fetch request was pending; o_hit tells the arbiter
// that the fetch side must win the next arbitration.
// Ports:
//   clk    : clock, all state on posedge
//   reset  : synchronous active-high reset
//   i_inc  : data grant issued while fetch request pending
//   i_clr  : fetch granted, or no fetch request pending
//   o_hit  : counter has reached LIMIT
// -----------------------------------------------------------------------------
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);

    localparam int            CW  = cnt_width(LIMIT);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    // Next count: clear wins, increment saturates at LIM.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = {CW{1'b0}};
        end else if (i_inc && (r_cnt != LIM)) begin
            w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= {CW{1'b0}};
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_hit = (r_cnt == LIM);

endmodule : arb_starve_cnt

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between an instruction-fetch requester (i_*) and a
// load/store requester (d_*). At most one transaction is outstanding; a new
// grant may be issued in the same cycle the previous response returns.
// Data has priority; with MEM_ARB_STARVE_GUARD_EN defined, fetch wins once
// STARVE_LIMIT consecutive data grants were given while i_req was waiting.
// Without the macro, data priority is strict and no counter exists.
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   i_req, i_addr, i_flush     : fetch request / address / redirect
//   i_gnt, i_rvalid, i_rdata   : fetch accept / response pulse / data
//   d_req, d_we, d_be, d_addr,
//   d_wdata                    : data request and command fields
//   d_gnt, d_rvalid, d_rdata   : data accept / response or write ack / data
//   mem_req, mem_we, mem_be,
//   mem_addr, mem_wdata        : shared memory command (grant cycle only)
//   mem_rvalid, mem_rdata      : memory response, one per mem_req
//   busy                       : transaction outstanding
//
// Grant, mem_req and command fields are combinational from the requests so a
// grant costs no extra cycle; responses are forwarded in the cycle they arrive.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int AW           = 32
) (
    input  logic          clk,
    input  logic          reset,
    // fetch side
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_flush,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    // data side
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    // memory port
    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    // status
    output logic          busy
);

    if (STARVE_LIMIT < 0) begin : g_bad_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be non-negative");
    end

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_drop;
    logic       w_drop_nxt;

    logic w_resp;
    logic w_grant_slot;
    logic w_fetch_win;
    logic w_i_gnt;
    logic w_d_gnt;
    logic w_starve_hit;

`ifdef MEM_ARB_STARVE_GUARD_EN
    arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_d_gnt && i_req),
        .i_clr (w_i_gnt || !i_req),
        .o_hit (w_starve_hit)
    );
`else
    assign w_starve_hit = 1'b0;
`endif

    // Arbitration: a grant slot exists in IDLE or when the outstanding
    // response arrives; responses in IDLE are spurious and open no slot.
    always_comb begin
        w_resp       = mem_rvalid && (r_state != ST_IDLE);
        w_grant_slot = !reset && ((r_state == ST_IDLE) || w_resp);
        w_fetch_win  = i_req && (!d_req || w_starve_hit);
        w_i_gnt      = w_grant_slot && w_fetch_win;
        w_d_gnt      = w_grant_slot && d_req && !w_fetch_win;
    end

    // Memory command: driven only in a grant cycle, zero otherwise.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = 32'h0000_0000;
        if (w_i_gnt) begin
            mem_req  = 1'b1;
            mem_be   = 4'hF;
            mem_addr = i_addr;
        end else if (w_d_gnt) begin
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else begin
            mem_req = 1'b0;
        end
    end

    // Requester-facing outputs. A flush coinciding with the fetch response
    // discards that response as well.
    always_comb begin
        i_gnt    = w_i_gnt;
        d_gnt    = w_d_gnt;
        i_rvalid = !reset && (r_state == ST_WAIT_I) && mem_rvalid
                   && !r_drop && !i_flush;
        d_rvalid = !reset && (r_state == ST_WAIT_D) && mem_rvalid;
        busy     = !reset && (r_state != ST_IDLE);
        if (i_rvalid) begin
            i_rdata = mem_rdata;
        end else begin
            i_rdata = 32'h0000_0000;
        end
        if (d_rvalid) begin
            d_rdata = mem_rdata;
        end else begin
            d_rdata = 32'h0000_0000;
        end
    end

    // Next-state logic; an illegal encoding recovers to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_WAIT_I, ST_WAIT_D: begin
                if (w_i_gnt) begin
                    w_state_nxt = ST_WAIT_I;
                end else if (w_d_gnt) begin
                    w_state_nxt = ST_WAIT_D;
                end else if (w_resp) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Drop flag: marks the outstanding fetch as stale after a redirect.
    // It is consumed by that fetch's response; a flush during a new fetch
    // grant re-arms it for the new transaction.
    always_comb begin
        w_drop_nxt = r_drop;
        if ((r_state == ST_WAIT_I) && mem_rvalid) begin
            w_drop_nxt = 1'b0;
        end else if ((r_state == ST_WAIT_I) && i_flush) begin
            w_drop_nxt = 1'b1;
        end else begin
            w_drop_nxt = r_drop;
        end
        if (w_i_gnt && i_flush) begin
            w_drop_nxt = 1'b1;
        end else begin
            w_drop_nxt = w_drop_nxt;
        end
    end

    // State and drop flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_flush, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    bit exp_seq [7];
    int d_issued;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4), .AW(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        sb.push_back(e);
    endtask

    // Sample on the falling edge; responses are popped from the scoreboard.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        chk("gnt_exclusive", {31'h0, i_gnt & d_gnt}, 32'h0);
        chk("mem_req_only_on_gnt", {31'h0, mem_req}, {31'h0, i_gnt | d_gnt});
        if (i_rvalid) begin
            if (sb.size() == 0) begin
                chk("i_rvalid_unexpected", {31'h0, i_rvalid}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("i_resp_kind", {31'h0, e.is_d}, 32'h0);
                chk("i_rdata", i_rdata, e.data);
            end
        end
        if (d_rvalid) begin
            if (sb.size() == 0) begin
                chk("d_rvalid_unexpected", {31'h0, d_rvalid}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("d_resp_kind", {31'h0, e.is_d}, 32'h1);
                chk("d_rdata", d_rdata, e.data);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        reset = 1'b1; i_req = 1'b0; i_addr = 32'h0; i_flush = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0; d_wdata = 32'h0;
        mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // reset holds everything quiet even with a request present
        sample();
        chk("rst_d_gnt", {31'h0, d_gnt}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        adv();
        reset = 1'b0; d_req = 1'b0;
        sample();
        chk("post_rst_busy", {31'h0, busy}, 32'h0);
        adv();

        // lone fetch, response three cycles after grant
        i_req = 1'b1; i_addr = 32'h100;
        sample();
        chk("f_gnt", {31'h0, i_gnt}, 32'h1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_we", {31'h0, mem_we}, 32'h0);
        chk("f_busy_c0", {31'h0, busy}, 32'h0);
        adv();
        i_req = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            sample();
            chk("f_busy_wait", {31'h0, busy}, 32'h1);
            adv();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013; push(1'b0, 32'h0000_0013);
        sample();
        chk("f_busy_c3", {31'h0, busy}, 32'h1);
        adv();
        mem_rvalid = 1'b0;
        sample();
        chk("f_idle_after", {31'h0, busy}, 32'h0);
        adv();

        // simultaneous requests: data first, fetch granted in d_rvalid cycle
        i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_addr = 32'h2000;
        sample();
        chk("both_d_gnt", {31'h0, d_gnt}, 32'h1);
        chk("both_i_gnt", {31'h0, i_gnt}, 32'h0);
        chk("both_mem_addr", mem_addr, 32'h2000);
        adv();
        d_req = 1'b0;
        sample();
        chk("both_wait_no_gnt", {31'h0, i_gnt}, 32'h0);
        adv();
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001; push(1'b1, 32'hCAFE_0001);
        sample();
        chk("both_b2b_i_gnt", {31'h0, i_gnt}, 32'h1);
        chk("both_b2b_addr", mem_addr, 32'h200);
        adv();
        i_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222; push(1'b0, 32'h1111_2222);
        sample();
        adv();
        mem_rvalid = 1'b0;

        // store command fields and write ack
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h3000; d_wdata = 32'h1234;
        sample();
        chk("st_gnt", {31'h0, d_gnt}, 32'h1);
        chk("st_mem_we", {31'h0, mem_we}, 32'h1);
        chk("st_mem_be", {28'h0, mem_be}, 32'h3);
        chk("st_mem_wdata", mem_wdata, 32'h1234);
        adv();
        d_req = 1'b0; d_we = 1'b0; d_be = 4'hF;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_ACED; push(1'b1, 32'h0000_ACED);
        sample();
        adv();
        mem_rvalid = 1'b0;

        // starvation: data held for six transactions while fetch waits
        i_req = 1'b1; i_addr = 32'h400; d_req = 1'b1; d_addr = 32'h5000; d_issued = 0;
        for (int g = 0; g < 7; g++) begin
            sample();
            chk($sformatf("starve_gnt%0d", g), {30'h0, i_gnt, d_gnt},
                exp_seq[g] ? 32'h1 : 32'h2);
            adv();
            mem_rvalid = 1'b0;
            if (exp_seq[g]) begin
                d_issued++;
                d_addr = d_addr + 32'h4;
                if (d_issued == 6) d_req = 1'b0;
            end else begin
                i_req = 1'b0;
            end
            sample();
            chk("starve_busy", {31'h0, busy}, 32'h1);
            adv();
            mem_rvalid = 1'b1; mem_rdata = 32'hB000 + 32'(g);
            push(exp_seq[g], 32'hB000 + 32'(g));
        end
        sample();
        chk("starve_tail_no_gnt", {30'h0, i_gnt, d_gnt}, 32'h0);
        adv();
        mem_rvalid = 1'b0;

        // flush after fetch grant drops that response
        i_req = 1'b1; i_addr = 32'h600;
        sample();
        chk("fl_gnt", {31'h0, i_gnt}, 32'h1);
        adv();
        i_req = 1'b0; i_flush = 1'b1;
        sample();
        adv();
        i_flush = 1'b0;
        sample();
        adv();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        sample();
        chk("fl_dropped", {31'h0, i_rvalid}, 32'h0);
        adv();
        mem_rvalid = 1'b0;
        i_req = 1'b1; i_addr = 32'h604;
        sample();
        chk("fl_next_gnt", {31'h0, i_gnt}, 32'h1);
        adv();
        i_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0073; push(1'b0, 32'h0000_0073);
        sample();
        adv();
        mem_rvalid = 1'b0;

        // flush in IDLE has no lasting effect
        i_flush = 1'b1;
        sample();
        chk("fl_idle_no_gnt", {31'h0, i_gnt}, 32'h0);
        adv();
        i_flush = 1'b0; i_req = 1'b1; i_addr = 32'h700;
        sample();
        adv();
        i_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077; push(1'b0, 32'h0000_0077);
        sample();
        adv();
        mem_rvalid = 1'b0;

        // spurious response in IDLE
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        sample();
        chk("spur_busy", {31'h0, busy}, 32'h0);
        adv();
        mem_rvalid = 1'b0;

        // reset mid-transaction abandons it
        d_req = 1'b1; d_addr = 32'h8000;
        sample();
        chk("rmid_gnt", {31'h0, d_gnt}, 32'h1);
        adv();
        d_req = 1'b0; reset = 1'b1;
        sample();
        chk("rmid_busy_in_rst", {31'h0, busy}, 32'h0);
        adv();
        reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055;
        sample();
        chk("rmid_d_rvalid", {31'h0, d_rvalid}, 32'h0);
        chk("rmid_busy", {31'h0, busy}, 32'h0);
        adv();
        mem_rvalid = 1'b0;
        sample();
        chk("rmid_idle", {31'h0, busy}, 32'h0);

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_port_arbiter
